// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding and default geometry for the SRAM bank.
package sram_pkg;
    localparam int DEF_A_WIDTH = 15;
    localparam int DEF_D_WIDTH = 8;
    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: aligns RAM read data with its valid flag over 1 or 2 cycles, output zeroed when not valid.
module sram_rd_pipe #(
    parameter int D_WIDTH    = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               rd_acc,
    input  logic [D_WIDTH-1:0] rd_data,
    output logic               valid,
    output logic [D_WIDTH-1:0] data
);
    logic               v1;
    logic               v2;
    logic [D_WIDTH-1:0] d2;
    always_ff @(posedge Clk) begin
        v1 <= !Rst && rd_acc;
        v2 <= !Rst && v1;
        d2 <= rd_data;
    end
    assign valid = (RD_LATENCY == 2) ? v2 : v1;
    assign data  = valid ? ((RD_LATENCY == 2) ? d2 : rd_data) : '0;
endmodule

// File: rtl/sram_bank.sv
// sram_bank: single-port-per-direction SRAM with full-memory clear sweep and pipelined reads.
module sram_bank
    import sram_pkg::*;
#(
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter int D_WIDTH    = DEF_D_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic               RW,
    input  logic [A_WIDTH-1:0] Addr,
    input  logic [D_WIDTH-1:0] Data_In,
    input  logic               Clr,
    output logic [D_WIDTH-1:0] Data_Out,
    output logic               Valid,
    output logic               Busy,
    output logic               Drop
);
    logic [D_WIDTH-1:0] mem [2**A_WIDTH];
    logic [D_WIDTH-1:0] ram_q;
    logic [A_WIDTH-1:0] clr_addr;
    state_t             state;
    logic               take;
    logic               wr;
    logic               rd;
    logic               sweep;
    always_comb begin
        take  = state == IDLE && !Clr;
        wr    = !Rst && take && En && RW;
        rd    = !Rst && take && En && !RW;
        sweep = !Rst && state == CLEAR;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            Drop     <= 1'b0;
        end else begin
            Drop <= En && !take;
            if (state == IDLE) begin
                if (Clr) begin
                    state    <= CLEAR;
                    clr_addr <= '0;
                end
            end else begin
                clr_addr <= clr_addr + 1'b1;
                if (&clr_addr) state <= IDLE;
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (wr || sweep) mem[sweep ? clr_addr : Addr] <= sweep ? '0 : Data_In;
        if (rd) ram_q <= mem[Addr];
    end
    assign Busy = state == CLEAR;
    sram_rd_pipe #(.D_WIDTH(D_WIDTH), .RD_LATENCY(RD_LATENCY)) u_rd_pipe (
        .Clk(Clk),
        .Rst(Rst),
        .rd_acc(rd),
        .rd_data(ram_q),
        .valid(Valid),
        .data(Data_Out)
    );
endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: scoreboard bench driving latency-1 and latency-2 banks with identical directed stimulus.
module tb_sram_bank;
    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    logic       Clk = 0;
    logic       Rst = 1;
    logic       En = 0;
    logic       RW = 0;
    logic [3:0] Addr = '0;
    logic [7:0] Data_In = '0;
    logic       Clr = 0;
    logic [7:0] d1, d2;
    logic       v1, v2, busy1, busy2, drop1, drop2;
    int         cyc = 0;
    int         pass = 0;
    int         total = 0;
    bit         mon_on = 0;
    exp_t       q [2][$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    sram_bank #(.A_WIDTH(4), .D_WIDTH(8), .RD_LATENCY(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .En(En), .RW(RW), .Addr(Addr), .Data_In(Data_In), .Clr(Clr),
        .Data_Out(d1), .Valid(v1), .Busy(busy1), .Drop(drop1)
    );
    sram_bank #(.A_WIDTH(4), .D_WIDTH(8), .RD_LATENCY(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .En(En), .RW(RW), .Addr(Addr), .Data_In(Data_In), .Clr(Clr),
        .Data_Out(d2), .Valid(v2), .Busy(busy2), .Drop(drop2)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic mon(int id, logic v, logic [7:0] d);
        exp_t e;
        if (v) begin
            if (q[id].size() == 0) begin
                total++;
                $display("FAIL unexpected_valid_L%0d: got data %0h expected no Valid at cycle %0d", id + 1, d, cyc);
            end else begin
                e = q[id].pop_front();
                chk($sformatf("rd_data_L%0d", id + 1), d, e.d);
                chk($sformatf("rd_cycle_L%0d", id + 1), cyc, e.due);
            end
        end else chk($sformatf("idle_zero_L%0d", id + 1), d, 0);
    endtask

    always @(negedge Clk) if (mon_on) begin
        mon(0, v1, d1);
        mon(1, v2, d2);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        En = 1; RW = 1; Addr = a; Data_In = d;
        step();
        En = 0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        En = 1; RW = 0; Addr = a;
        q[0].push_back('{d: exp, due: cyc + 1});
        q[1].push_back('{d: exp, due: cyc + 2});
        step();
        En = 0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while ((busy1 || busy2) && n < 40) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        step();
        Rst = 0;
        mon_on = 1;
        chk("rst_busy_L1", busy1, 1);
        chk("rst_busy_L2", busy2, 1);
        chk("rst_drop", drop1 | drop2, 0);
        wait_idle(n);
        chk("rst_sweep_len", n, 16);
        chk("rst_sweep_done_L2", busy2, 0);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);
        repeat (3) step();

        wr(4'd3, 8'hA5);
        rd(4'd3, 8'hA5);
        chk("no_drop_idle", drop1 | drop2, 0);
        for (int i = 0; i < 4; i++) wr(4'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) rd(4'(i), 8'h10 + 8'(i));
        repeat (3) step();

        for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF);
        Clr = 1; En = 1; RW = 0; Addr = 4'd7;
        step();
        Clr = 0; En = 0;
        chk("clr_drop_L1", drop1, 1);
        chk("clr_drop_L2", drop2, 1);
        chk("clr_busy", busy1, 1);
        wait_idle(n);
        chk("clr_sweep_len", n, 16);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);
        repeat (3) step();

        wr(4'd5, 8'h55);
        rd(4'd5, 8'h55);
        Clr = 1;
        step();
        Clr = 0;
        repeat (3) step();
        wr(4'd0, 8'h77);
        chk("busy_drop_L1", drop1, 1);
        chk("busy_drop_L2", drop2, 1);
        Clr = 1;
        step();
        Clr = 0;
        wait_idle(n);
        chk("no_restart_len", n, 11);
        rd(4'd0, 8'h00);
        rd(4'd5, 8'h00);
        repeat (3) step();

        wr(4'd9, 8'hC3);
        wr(4'd15, 8'h3C);
        Clr = 1;
        step();
        Clr = 0;
        repeat (8) step();
        Rst = 1; En = 1; RW = 1; Addr = 4'd15; Data_In = 8'h99;
        step();
        Rst = 0; En = 0;
        chk("rst_mid_busy", busy1 & busy2, 1);
        chk("rst_over_en_drop", drop1 | drop2, 0);
        wait_idle(n);
        chk("rst_mid_sweep_len", n, 16);
        rd(4'd9, 8'h00);
        rd(4'd15, 8'h00);
        repeat (4) step();
        chk("sb_empty_L1", q[0].size(), 0);
        chk("sb_empty_L2", q[1].size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 Parameter A_WIDTH, default 15, address width; depth SHALL be 2**A_WIDTH words.
REQ-002 Parameter D_WIDTH, default 8, data word width.
REQ-003 Parameter RD_LATENCY, default 1, legal values 1 or 2: cycles from accepted read to Data_Out.
REQ-004 Clk  in  1  clock; all logic on rising edge.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 En  in  1  access request.
REQ-007 RW  in  1  1 = write, 0 = read; sampled only when En=1.
REQ-008 Addr  in  A_WIDTH  word address.
REQ-009 Data_In  in  D_WIDTH  write data.
REQ-010 Clr  in  1  request a full-memory clear sweep.
REQ-011 Data_Out  out  D_WIDTH  read data; 0 whenever Valid=0.
REQ-012 Valid  out  1  Data_Out carries read data this cycle.
REQ-013 Busy  out  1  clear sweep in progress; accesses not accepted.
REQ-014 Drop  out  1  one-cycle pulse: a request (En=1) in the previous cycle was rejected.

Function
REQ-015 FSM states IDLE and CLEAR; counter Clr_Addr of A_WIDTH bits.
REQ-016 IDLE, Clr=1: go to CLEAR with Clr_Addr=0; Clr has priority over a same-cycle En=1 access, which is dropped (Drop=1 next cycle).
REQ-017 CLEAR: each cycle write 0 to Memory[Clr_Addr] and increment Clr_Addr; after writing 2**A_WIDTH-1, return to IDLE; sweep = exactly 2**A_WIDTH cycles.
REQ-018 Busy=1 exactly while state=CLEAR (registered output of state).
REQ-019 CLEAR: En=1 is rejected (Drop=1 next cycle); Clr=1 is ignored, no restart.
REQ-020 IDLE, En=1, RW=1, Clr=0: Memory[Addr] <= Data_In at that edge; no Valid generated.
REQ-021 IDLE, En=1, RW=0, Clr=0: read accepted; Valid=1 and Data_Out=Memory[Addr] exactly RD_LATENCY cycles later, for one cycle.
REQ-022 Back-to-back reads SHALL be accepted every cycle; pipeline throughput 1 read/cycle, order preserved.
REQ-023 Write at cycle N followed by read of same address at cycle N+1 SHALL return the new data.
REQ-024 Reads already in the pipeline when a clear starts SHALL complete with the pre-clear data.
REQ-025 Addr wrap: Clr_Addr SHALL roll over to 0 on terminal count without spurious extra write.

Reset
REQ-026 Rst=1: state forced to CLEAR, Clr_Addr=0, read pipeline flushed; Valid=0, Data_Out=0, Drop=0, Busy=1 in the cycle after Rst is sampled.
REQ-027 After Rst falls, sweep runs 2**A_WIDTH cycles, then Busy=0; memory contents all 0 on exit.
REQ-028 Rst during a sweep SHALL restart it at address 0; Rst overrides Clr, En.
REQ-029 Memory array itself has no reset term; zeroing only via sweep.

Structure
REQ-030 Shared package sram_pkg SHALL hold the state enum (IDLE, CLEAR) and default A_WIDTH/D_WIDTH constants.
REQ-031 Read-data delay stage SHALL be sub-module sram_rd_pipe (parameter RD_LATENCY, carries data+valid, flushed by Rst).
REQ-032 Memory SHALL be single write port, single read port, inferable as block RAM.

Verification (A_WIDTH=4, D_WIDTH=8)
REQ-033 Rst 1 cycle -> Busy=1 for 16 cycles, then 0; read all 16 addresses -> each Data_Out=8'h00.
REQ-034 RD_LATENCY=1: write 8'hA5 @3, next cycle read @3 -> Valid=1, Data_Out=8'hA5 one cycle later; RD_LATENCY=2 -> two cycles later.
REQ-035 Reads @0..@3 back-to-back after writing 8'h10..8'h13 -> four consecutive Valid cycles, 8'h10..8'h13 in order.
REQ-036 Write 8'hFF everywhere, Clr=1 with En=1 read same cycle -> Drop=1 next cycle, Busy 16 cycles, subsequent reads 8'h00.
REQ-037 Read @5 accepted one cycle before Clr -> Valid with pre-clear data 8'h55; En=1 during Busy -> Drop=1, memory unchanged.
REQ-038 Rst asserted at sweep cycle 8 -> Busy stays 1, sweep restarts, completes 16 cycles after Rst falls.
